// File: rtl/matavimo_valdiklis.sv
`default_nettype none
// ============================================================================
// Module   : matavimo_valdiklis
// Brief    : TDC channel sequencer: coarse count between start/stop hits,
//            fine code capture, summer strobe, result handshake.
//            Optional averaging series: define MATAVIMO_VIDURKIS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matavimo_valdiklis #(
  parameter int size_frontu = 8,
  parameter int size_grubus = 10,
  parameter int TIMEOUT_CYC = 200,
  parameter int AVG_LOG2    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_req,
  input  logic                   abort,
  input  logic                   start_hit,
  input  logic                   stop_hit,
  input  logic [size_frontu-1:0] fine_in,
  output logic [size_frontu-1:0] grubus,
  output logic [size_frontu-1:0] teigiamas_f,
  output logic [size_frontu-1:0] neigiamas_f,
  output logic                   enable,
  input  logic [size_grubus-1:0] Laikas,
  output logic [size_grubus-1:0] result,
  output logic                   result_err,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_armed = 3'd1;
  localparam logic [2:0] c_run   = 3'd2;
  localparam logic [2:0] c_latch = 3'd3;
  localparam logic [2:0] c_capt  = 3'd4;
  localparam logic [2:0] c_out   = 3'd5;

  localparam logic [size_frontu-1:0] c_tmo_last = size_frontu'(TIMEOUT_CYC - 1);

  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > (1 << size_frontu) - 1) || (AVG_LOG2 < 0)) begin : g_param_chk
    $error("matavimo_valdiklis: parameter out of range");
  end

  logic [2:0]             state_q, state_d;
  logic [size_frontu-1:0] cnt_q;
  logic [size_frontu-1:0] grubus_q, teig_q, neig_q;
  logic [size_grubus-1:0] result_q;
  logic                   err_q;

  logic                   w_timeout;
  logic                   w_last;
  logic [size_grubus-1:0] w_capt_res;

  assign w_timeout = (cnt_q == c_tmo_last);

`ifdef MATAVIMO_VIDURKIS_EN
  localparam int c_acc_w = size_grubus + AVG_LOG2;
  localparam int c_idx_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'((1 << AVG_LOG2) - 1);

  logic [c_acc_w-1:0] acc_q;
  logic [c_acc_w-1:0] w_sum;
  logic [c_idx_w-1:0] idx_q;

  assign w_sum      = acc_q + c_acc_w'(Laikas);
  assign w_last     = (idx_q == c_idx_last);
  assign w_capt_res = w_sum[c_acc_w-1:AVG_LOG2];

  // Series bookkeeping restarts whenever the channel leaves a series.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (abort || (state_q == c_idle) ||
                 ((state_q == c_run) && !stop_hit && w_timeout)) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (state_q == c_capt) begin
      if (w_last) begin
        acc_q <= '0;
        idx_q <= '0;
      end else begin
        acc_q <= w_sum;
        idx_q <= idx_q + 1'b1;
      end
    end
  end
`else
  assign w_last     = 1'b1;
  assign w_capt_res = Laikas;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (start_req) state_d = c_armed;
      c_armed: if (start_hit) state_d = stop_hit ? c_latch : c_run;
      c_run: begin
        if (stop_hit) begin
          state_d = c_latch;
        end else if (w_timeout) begin
          state_d = c_out;
        end
      end
      c_latch: state_d = c_capt;
      c_capt:  state_d = w_last ? c_out : c_armed;
      c_out:   if (result_ready) state_d = c_idle;
      default: state_d = c_idle;
    endcase
    if (abort) begin
      state_d = c_idle;
    end
  end

  always_comb begin
    enable       = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state_q)
      c_idle:  busy         = 1'b0;
      c_latch: enable       = 1'b1;
      c_out:   result_valid = 1'b1;
      default: ;
    endcase
  end

  // Stop k cycles after start yields cnt_q = k-1 at the stop edge, hence +1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      grubus_q <= '0;
      teig_q   <= '0;
      neig_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (!abort) begin
      case (state_q)
        c_armed: begin
          if (start_hit) begin
            cnt_q  <= '0;
            teig_q <= fine_in;
            if (stop_hit) begin
              neig_q   <= fine_in;
              grubus_q <= '0;
            end
          end
        end
        c_run: begin
          cnt_q <= cnt_q + 1'b1;
          if (stop_hit) begin
            grubus_q <= cnt_q + 1'b1;
            neig_q   <= fine_in;
          end else if (w_timeout) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        c_capt: begin
          if (w_last) begin
            result_q <= w_capt_res;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign grubus      = grubus_q;
  assign teigiamas_f = teig_q;
  assign neigiamas_f = neig_q;
  assign result      = result_q;
  assign result_err  = err_q;

endmodule
`default_nettype wire
